// File: rtl/spdif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spdif_pkg
// Purpose  : Shared types and constants for the S/PDIF transmit path
//            (sequencer and frame assembler).
// Revision : 1.0 - initial release
// ============================================================================
package spdif_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    RUN     = 2'd2
  } tx_ctrl_state_t;

  localparam int FRAMES_PER_BLOCK = 192;
  localparam int SAMPLE_W         = 20;
  localparam int FRAME_IDX_W      = 8;

  // Block position advance, wrapping at the channel-status block length.
  function automatic logic [FRAME_IDX_W-1:0] next_frame_idx(input logic [FRAME_IDX_W-1:0] idx);
    return (idx == FRAME_IDX_W'(FRAMES_PER_BLOCK - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spdif_tx_controller.sv
`default_nettype none
// ============================================================================
// Module   : spdif_tx_controller
// Purpose  : Sequences FIFO samples into the S/PDIF frame assembler, tracks
//            block position and stops on block boundaries.
//            Option macro: SPDIF_MUTE_ON_UNDERRUN_EN (mute instead of stop).
// Revision : 1.0 - initial release
// ============================================================================
module spdif_tx_controller
  import spdif_pkg::*;
#(
  parameter int CNT_W         = 10,
  parameter int PREFILL_LEVEL = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [SAMPLE_W-1:0]    fifo_dout,
  input  logic                   fifo_empty,
  input  logic [CNT_W-1:0]       fifo_count,
  output logic                   fifo_rd_en,
  input  logic                   frame_req,
  output logic                   tx_enable,
  output logic [SAMPLE_W-1:0]    sample,
  output logic                   sample_valid,
  output logic [FRAME_IDX_W-1:0] frame_idx,
  output logic                   busy,
  output logic                   underrun
);

  tx_ctrl_state_t         r_state;
  tx_ctrl_state_t         w_next_state;
  logic                   r_req_d;
  logic                   r_stop_pending;
  logic                   r_rd_d1;
  logic                   r_rd_en;
  logic                   r_tx_enable;
  logic                   r_sample_valid;
  logic                   r_busy;
  logic                   r_underrun;
  logic [SAMPLE_W-1:0]    r_sample;
  logic [FRAME_IDX_W-1:0] r_frame_idx;

  logic                   w_req_rise;
  logic                   w_rd_en;
  logic                   w_underrun;
  logic                   w_mute;
  logic                   w_stop_pending;
  logic [FRAME_IDX_W-1:0] w_frame_idx;

  assign w_req_rise = frame_req & ~r_req_d;

  always_comb begin
    w_next_state   = r_state;
    w_rd_en        = 1'b0;
    w_underrun     = 1'b0;
    w_mute         = 1'b0;
    w_stop_pending = r_stop_pending;
    w_frame_idx    = r_frame_idx;
    case (r_state)
      IDLE: begin
        if (start && !stop) w_next_state = PREFILL;
      end
      PREFILL: begin
        if (stop)                                      w_next_state = IDLE;
        else if (fifo_count >= CNT_W'(PREFILL_LEVEL)) w_next_state = RUN;
      end
      RUN: begin
        if (stop) w_stop_pending = 1'b1;
        if (w_req_rise) begin
          // Block boundary reached with a stop queued: end without a pop.
          if (r_stop_pending && r_frame_idx == '0) begin
            w_next_state = IDLE;
          end else if (!fifo_empty) begin
            w_rd_en     = 1'b1;
            w_frame_idx = next_frame_idx(r_frame_idx);
          end else begin
            w_underrun = 1'b1;
`ifdef SPDIF_MUTE_ON_UNDERRUN_EN
            w_mute      = 1'b1;
            w_frame_idx = next_frame_idx(r_frame_idx);
`else
            w_next_state = IDLE;
`endif
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
    // Entering or leaving RUN restarts the block position and stop request.
    if (w_next_state != RUN || r_state != RUN) begin
      w_frame_idx    = '0;
      w_stop_pending = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_req_d        <= 1'b0;
      r_stop_pending <= 1'b0;
      r_rd_en        <= 1'b0;
      r_rd_d1        <= 1'b0;
      r_tx_enable    <= 1'b0;
      r_sample_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_underrun     <= 1'b0;
      r_sample       <= '0;
      r_frame_idx    <= '0;
    end else begin
      r_state        <= w_next_state;
      r_req_d        <= frame_req;
      r_stop_pending <= w_stop_pending;
      r_frame_idx    <= w_frame_idx;
      r_rd_en        <= w_rd_en;
      r_rd_d1        <= r_rd_en && (w_next_state == RUN);
      r_underrun     <= w_underrun;
      r_busy         <= (w_next_state != IDLE);
      r_tx_enable    <= (w_next_state == RUN);
      // FIFO data arrives the cycle after the pop; drop it if RUN is left.
      if (w_next_state != RUN) begin
        r_sample_valid <= 1'b0;
      end else if (w_mute) begin
        r_sample       <= '0;
        r_sample_valid <= 1'b1;
      end else if (r_rd_d1) begin
        r_sample       <= fifo_dout;
        r_sample_valid <= 1'b1;
      end
    end
  end

  assign fifo_rd_en   = r_rd_en;
  assign tx_enable    = r_tx_enable;
  assign sample       = r_sample;
  assign sample_valid = r_sample_valid;
  assign frame_idx    = r_frame_idx;
  assign busy         = r_busy;
  assign underrun     = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spdif_tx_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_spdif_tx_controller
// Purpose  : Directed self-checking bench for spdif_tx_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spdif_tx_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [19:0] fifo_dout;
  logic        fifo_empty = 1'b0;
  logic [9:0]  fifo_count = 10'd0;
  logic        fifo_rd_en;
  logic        frame_req = 1'b0;
  logic        tx_enable;
  logic [19:0] sample;
  logic        sample_valid;
  logic [7:0]  frame_idx;
  logic        busy;
  logic        underrun;

  logic [19:0] fifo_word = 20'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Registered-read FIFO: data valid only the cycle after a pop, garbage otherwise.
  always @(posedge clk) fifo_dout <= fifo_rd_en ? fifo_word : 20'h55555;

  spdif_tx_controller #(.CNT_W(10), .PREFILL_LEVEL(256)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_count   (fifo_count),
    .fifo_rd_en   (fifo_rd_en),
    .frame_req    (frame_req),
    .tx_enable    (tx_enable),
    .sample       (sample),
    .sample_valid (sample_valid),
    .frame_idx    (frame_idx),
    .busy         (busy),
    .underrun     (underrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(output logic rd, output logic ur);
    frame_req = 1'b1;
    step();
    rd = fifo_rd_en;
    ur = underrun;
    frame_req = 1'b0;
    step();
    step();
  endtask

  logic rd, ur, early_tx;
  int   pops;

  initial begin
    fifo_dout = 20'h0;
    step();
    step();
    check_eq("rst_ctrl", {28'd0, tx_enable, fifo_rd_en, sample_valid, busy}, 32'd0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_sample", sample, 0);
    check_eq("rst_frame_idx", frame_idx, 0);
    rst = 1'b0;
    step();

    // start together with stop: stop wins
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_eq("start_stop_busy", busy, 0);

    // Prefill ramp
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("prefill_busy", busy, 1);
    early_tx = 1'b0;
    for (int c = 0; c < 256; c++) begin
      fifo_count = 10'(c);
      step();
      early_tx = early_tx | tx_enable;
    end
    check_eq("prefill_tx_low", early_tx, 0);
    fifo_count = 10'd256;
    step();
    check_eq("prefill_tx_rise", tx_enable, 1);
    check_eq("run_idx0", frame_idx, 0);

    // Serve one frame, holding frame_req high for two cycles
    fifo_word = 20'hABCDE;
    frame_req = 1'b1;
    step();
    check_eq("serve_rd_en", fifo_rd_en, 1);
    check_eq("serve_idx", frame_idx, 1);
    step();
    check_eq("serve_rd_single", fifo_rd_en, 0);
    frame_req = 1'b0;
    step();
    check_eq("serve_sample", sample, 32'hABCDE);
    check_eq("serve_valid", sample_valid, 1);

    // Advance to frame 57
    pops = 0;
    for (int i = 1; i < 57; i++) begin
      fifo_word = 20'(i * 3);
      do_frame(rd, ur);
      pops += int'(rd);
    end
    check_eq("adv_pops", pops, 56);
    check_eq("adv_idx57", frame_idx, 57);

    stop = 1'b1;
    step();
    stop = 1'b0;
    check_eq("stop_tx_held", tx_enable, 1);

    pops = 0;
    for (int i = 0; i < 135; i++) begin
      fifo_word = 20'(i * 7919 + 3);
      if (i == 134) check_eq("wrap_idx191", frame_idx, 191);
      do_frame(rd, ur);
      pops += int'(rd);
    end
    check_eq("block_pops", pops, 135);
    check_eq("wrap_idx0", frame_idx, 0);
    check_eq("block_last_sample", sample, 32'((134 * 7919 + 3) & 20'hFFFFF));
    check_eq("block_tx_still", tx_enable, 1);

    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    check_eq("bstop_no_pop", fifo_rd_en, 0);
    check_eq("bstop_tx", tx_enable, 0);
    check_eq("bstop_busy", busy, 0);
    check_eq("bstop_valid", sample_valid, 0);
    step();

    // frame_req outside RUN ignored
    do_frame(rd, ur);
    check_eq("idle_req_no_pop", rd, 0);

    // Restart (fifo_count still at prefill level)
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("restart_tx", tx_enable, 1);

    // Underrun
    fifo_empty = 1'b1;
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    check_eq("ur_pulse", underrun, 1);
    check_eq("ur_no_pop", fifo_rd_en, 0);
    step();
    check_eq("ur_pulse_end", underrun, 0);
`ifdef SPDIF_MUTE_ON_UNDERRUN_EN
    check_eq("ur_mute_sample", sample, 0);
    check_eq("ur_mute_valid", sample_valid, 1);
    check_eq("ur_mute_tx", tx_enable, 1);
    check_eq("ur_mute_idx", frame_idx, 1);
`else
    check_eq("ur_stop_tx", tx_enable, 0);
    check_eq("ur_stop_busy", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
`endif
    fifo_empty = 1'b0;

    // Asynchronous reset mid-RUN
    fifo_word = 20'h13579;
    do_frame(rd, ur);
    check_eq("pre_rst_valid", sample_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_ctrl", {28'd0, tx_enable, fifo_rd_en, sample_valid, busy}, 32'd0);
    check_eq("arst_sample", sample, 0);
    check_eq("arst_idx", frame_idx, 0);
    step();
    rst = 1'b0;
    step();
    check_eq("post_rst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
